elastic_pipe_reg: RTL and testbench
===================================

// Module: elastic_pipe_reg
// PURPOSE
//  Parametrised elastic pipeline register for the RISC-V pipeline (MEM/WB and similar boundaries).
//  Carries the writeback bundle: read data, ALU result, PC+4, rd, RegWrite and ResultSrc.
//  Chain of STAGES skid-buffered stages with valid/ready handshake and a synchronous flush.
//  Full throughput and a registered in_ready; sits between the data-memory stage and the register-file writeback.
// PARAMETERS
//  XLEN    32  width of read_data, alu_result, pc_plus4
//  RD_W    5   width of destination register index
//  STAGES  1   number of chained stages, 1..4
//  CNT_W   16  width of perf counters (only with PIPE_PERF_CNT_EN)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  reset          in   1      synchronous, active-low reset
//  flush          in   1      drop every in-flight entry
//  in_valid       in   1      upstream bundle valid
//  in_ready       out  1      stage accepts bundle this cycle
//  in_read_data   in   XLEN   memory read data
//  in_alu_result  in   XLEN   ALU result
//  in_pc_plus4    in   XLEN   PC+4
//  in_rd          in   RD_W   destination register
//  in_regwrite    in   1      register write enable
//  in_result_src  in   2      writeback mux select
//  out_valid      out  1      output bundle valid
//  out_ready      in   1      downstream (writeback) accepts
//  out_*          out  as in  registered copies of in_* fields
//  stall_cnt      out  CNT_W  cycles with out_valid=1 and out_ready=0 (macro only)
//  flush_cnt      out  CNT_W  flushes that discarded at least one valid entry (macro only)
// BEHAVIOUR
//  - Reset (reset==0 at a rising edge): all valid bits 0, all payload registers 0, out_* = 0, counters 0.
//    in_ready=0 while reset==0; in_ready=1 in the first cycle after release.
//  - Each stage holds main reg M and skid reg S. Transfer: accept = in_valid&in_ready; fire = out_valid&out_ready.
//  - Upstream in_ready = !S.valid of stage 0, taken from a register (no combinational path from out_ready).
//  - Stage states: EMPTY(M0,S0), ONE(M1,S0), TWO(M1,S1).
//    EMPTY: accept -> ONE (M<=in).
//    ONE:   accept&fire -> ONE (M<=in); accept&!fire -> TWO (S<=in); fire&!accept -> EMPTY.
//    TWO:   accept impossible; fire -> ONE (M<=S, S cleared); otherwise hold.
//  - Stage k's output feeds stage k+1's input. The last stage drives out_*; out_valid = M.valid.
//  - Latency without backpressure: STAGES cycles from accept to out_valid. Throughput: 1 bundle/cycle.
//  - Data integrity: bundles leave in order, never duplicated or dropped except by flush.
//    Payload is held stable while out_valid&!out_ready.
//  - out_regwrite = M.regwrite & M.valid, so no register write can leak from an invalid slot.
//  - flush==1 at an edge: every M/S valid bit is cleared; a bundle accepted in the same cycle is dropped.
//    in_ready=1 in the next cycle. Payload registers are not cleared.
//  - flush and reset together: reset wins; counters are cleared and flush_cnt does not increment.
//  - Mid-operation reset behaves identically to power-on reset and discards all contents.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//    - stall_cnt and flush_cnt ports exist.
//    - Both counters saturate at all-ones and never wrap.
//    - flush_cnt increments only if some valid bit was 1 at the flushing edge.
//  PIPE_PERF_CNT_EN undefined:
//    - The ports and counter logic are absent; behaviour is otherwise identical.
// TESTING
//  1) STAGES=1, out_ready=1, push rd=5, alu=ABCD0001, rd_data=12345678, pc4=20, rw=1, src=01
//     -> out_valid one cycle later with identical fields, then 0 the next cycle.
//  2) Stream 8 bundles (alu=1..8) back-to-back, out_ready=1
//     -> out_alu 1..8 on 8 consecutive cycles; in_ready never drops.
//  3) out_ready=0 while pushing 3 bundles
//     -> first held on output, second in skid, in_ready=0 after 2 accepts.
//     Release out_ready -> 1,2,3 in order, no loss.
//  4) STAGES=3, 3 entries in flight, flush=1 with in_valid=1
//     -> next cycle out_valid=0, out_regwrite=0, in_ready=1; no bundle appears later; flush_cnt=1.
//  5) Assert reset=0 mid-stream with the skid full
//     -> next cycle all valid=0, out_*=0, in_ready=0; after release, fresh bundle passes with STAGES latency.
//  6) Macro on, CNT_W=4, hold out_valid&!out_ready for 20 cycles
//     -> stall_cnt saturates at 15; rerun without macro compiles with no counter ports.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - chained skid-buffered pipeline register for the writeback bundle
// Optional perf counters (stall_cnt, flush_cnt) under `PIPE_PERF_CNT_EN.
module elastic_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int RD_W   = 5,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_read_data,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_regwrite,
    input  logic [1:0]      in_result_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_read_data,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [RD_W-1:0] out_rd,
    output logic            out_regwrite,
    output logic [1:0]      out_result_src
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int W = 3 * XLEN + RD_W + 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    if (STAGES < 1 || STAGES > 4 || CNT_W < 1) begin : g_bad_param
        $error("elastic_pipe_reg: STAGES must be 1..4 and CNT_W >= 1");
    end

    // link k is the input side of stage k; link STAGES is the module output
    logic [STAGES:0] link_valid;
    logic [STAGES:0] link_ready;
    logic [W-1:0]    link_data [0:STAGES];
    logic [STAGES-1:0] busy;
    logic            out_regwrite_raw;

    assign link_valid[0]      = in_valid;
    assign link_data[0]       = {in_read_data, in_alu_result, in_pc_plus4,
                                 in_rd, in_regwrite, in_result_src};
    assign link_ready[STAGES] = out_ready;
    assign in_ready           = link_ready[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        stage_state_e st_q, st_d;
        logic [W-1:0] m_q, m_d, s_q, s_d;
        logic         rdy_q;
        logic         accept, fire;

        assign accept = link_valid[g] & rdy_q;
        assign fire   = (st_q != EMPTY) & link_ready[g+1];

        always_comb begin
            st_d = st_q;
            m_d  = m_q;
            s_d  = s_q;
            case (st_q)
                EMPTY: begin
                    if (accept) begin
                        st_d = ONE;
                        m_d  = link_data[g];
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        m_d = link_data[g];
                    end else if (accept) begin
                        st_d = TWO;
                        s_d  = link_data[g];
                    end else if (fire) begin
                        st_d = EMPTY;
                    end
                end
                TWO: begin
                    if (fire) begin
                        st_d = ONE;
                        m_d  = s_q;
                    end
                end
                default: st_d = EMPTY;
            endcase
        end

        // rdy_q mirrors "skid empty" one cycle ahead, so in_ready never depends on out_ready
        always_ff @(posedge clk) begin
            if (!reset) begin
                st_q  <= EMPTY;
                m_q   <= '0;
                s_q   <= '0;
                rdy_q <= 1'b0;
            end else if (flush) begin
                st_q  <= EMPTY;
                rdy_q <= 1'b1;
            end else begin
                st_q  <= st_d;
                m_q   <= m_d;
                s_q   <= s_d;
                rdy_q <= (st_d != TWO);
            end
        end

        assign link_ready[g]   = rdy_q;
        assign link_valid[g+1] = (st_q != EMPTY);
        assign link_data[g+1]  = m_q;
        assign busy[g]         = (st_q != EMPTY);
    end

    assign out_valid = link_valid[STAGES];
    assign {out_read_data, out_alu_result, out_pc_plus4,
            out_rd, out_regwrite_raw, out_result_src} = link_data[STAGES];
    assign out_regwrite = out_regwrite_raw & out_valid;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush && (|busy) && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - directed self-checking bench for elastic_pipe_reg (STAGES=1 and 3)
module tb_elastic_pipe_reg;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, out_ready;
    logic [31:0] in_read_data, in_alu_result, in_pc_plus4;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic [1:0]  in_result_src;

    logic        o1_in_ready, o1_valid, o1_rw;
    logic [31:0] o1_rdata, o1_alu, o1_pc4;
    logic [4:0]  o1_rd;
    logic [1:0]  o1_src;
    logic        o3_in_ready, o3_valid, o3_rw;
    logic [31:0] o3_rdata, o3_alu, o3_pc4;
    logic [4:0]  o3_rd;
    logic [1:0]  o3_src;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0]  o1_stall_cnt, o1_flush_cnt, o3_stall_cnt, o3_flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    elastic_pipe_reg #(.XLEN(32), .RD_W(5), .STAGES(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_read_data(in_read_data), .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_result_src(in_result_src),
        .out_valid(o1_valid), .out_ready(out_ready),
        .out_read_data(o1_rdata), .out_alu_result(o1_alu), .out_pc_plus4(o1_pc4),
        .out_rd(o1_rd), .out_regwrite(o1_rw), .out_result_src(o1_src)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(o1_stall_cnt), .flush_cnt(o1_flush_cnt)
`endif
    );

    elastic_pipe_reg #(.XLEN(32), .RD_W(5), .STAGES(3), .CNT_W(4)) u3 (
        .clk(clk), .reset(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(o3_in_ready),
        .in_read_data(in_read_data), .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_result_src(in_result_src),
        .out_valid(o3_valid), .out_ready(out_ready),
        .out_read_data(o3_rdata), .out_alu_result(o3_alu), .out_pc_plus4(o3_pc4),
        .out_rd(o3_rd), .out_regwrite(o3_rw), .out_result_src(o3_src)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(o3_stall_cnt), .flush_cnt(o3_flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] alu);
        in_valid      = 1'b1;
        in_alu_result = alu;
        in_read_data  = alu ^ 32'h5A5A_0000;
        in_pc_plus4   = alu << 2;
        in_rd         = alu[4:0];
        in_regwrite   = 1'b1;
        in_result_src = 2'b00;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        logic seen;
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_read_data = '0; in_alu_result = '0; in_pc_plus4 = '0;
        in_rd = '0; in_regwrite = 1'b0; in_result_src = '0;

        // reset state
        tick();
        tick();
        check("rst_in_ready", o1_in_ready, 0);
        check("rst_out_valid", o1_valid, 0);
        check("rst_out_alu", o1_alu, 0);
        check("rst_out_rw", o1_rw, 0);
`ifdef PIPE_PERF_CNT_EN
        check("rst_stall_cnt", o1_stall_cnt, 0);
        check("rst_flush_cnt", o1_flush_cnt, 0);
`endif
        resetn = 1'b1;
        tick();
        check("rel_in_ready", o1_in_ready, 1);

        // 1) single bundle, STAGES=1
        in_valid = 1'b1; in_rd = 5'd5; in_alu_result = 32'hABCD_0001;
        in_read_data = 32'h1234_5678; in_pc_plus4 = 32'h20;
        in_regwrite = 1'b1; in_result_src = 2'b01;
        tick();
        in_valid = 1'b0;
        check("t1_valid", o1_valid, 1);
        check("t1_rd", o1_rd, 5);
        check("t1_alu", o1_alu, 32'hABCD_0001);
        check("t1_rdata", o1_rdata, 32'h1234_5678);
        check("t1_pc4", o1_pc4, 32'h20);
        check("t1_rw", o1_rw, 1);
        check("t1_src", o1_src, 2'b01);
        tick();
        check("t1_valid_after", o1_valid, 0);
        check("t1_rw_after", o1_rw, 0);

        // 2) 8 back-to-back bundles
        for (int i = 1; i <= 8; i++) begin
            push(i);
            tick();
            check("t2_in_ready", o1_in_ready, 1);
            check("t2_valid", o1_valid, 1);
            check("t2_alu", o1_alu, i);
        end
        in_valid = 1'b0;
        tick();
        check("t2_drain", o1_valid, 0);

        // 3) backpressure fills the skid, then release
        out_ready = 1'b0;
        push(1);
        tick();
        check("t3_ready_1", o1_in_ready, 1);
        check("t3_alu_1", o1_alu, 1);
        push(2);
        tick();
        check("t3_ready_full", o1_in_ready, 0);
        check("t3_alu_hold", o1_alu, 1);
        push(3);
        tick();
        check("t3_still_full", o1_in_ready, 0);
        check("t3_alu_stable", o1_alu, 1);
        out_ready = 1'b1;
        tick();
        check("t3_alu_2", o1_alu, 2);
        check("t3_ready_back", o1_in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t3_alu_3", o1_alu, 3);
        check("t3_valid_3", o1_valid, 1);
        tick();
        check("t3_empty", o1_valid, 0);

        // 4) STAGES=3 flush with bundles in flight
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push(i);
            tick();
        end
        check("t4_lat3_valid", o3_valid, 1);
        check("t4_lat3_alu", o3_alu, 1);
        push(9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t4_valid", o3_valid, 0);
        check("t4_rw", o3_rw, 0);
        check("t4_in_ready", o3_in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= o3_valid;
        end
        check("t4_no_ghost", seen, 0);
`ifdef PIPE_PERF_CNT_EN
        check("t4_flush_cnt", o3_flush_cnt, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_empty", o3_flush_cnt, 1);
`endif

        // 5) mid-stream reset with skid full
        out_ready = 1'b0;
        push(4);
        tick();
        push(5);
        tick();
        in_valid = 1'b0;
        check("t5_full", o1_in_ready, 0);
        resetn = 1'b0;
        tick();
        check("t5_valid", o1_valid, 0);
        check("t5_alu", o1_alu, 0);
        check("t5_rd", o1_rd, 0);
        check("t5_in_ready", o1_in_ready, 0);
        resetn = 1'b1;
        out_ready = 1'b1;
        tick();
        check("t5_rel_ready", o1_in_ready, 1);
        push(32'h77);
        tick();
        in_valid = 1'b0;
        check("t5_s1_valid", o1_valid, 1);
        check("t5_s1_alu", o1_alu, 32'h77);
        tick();
        check("t5_s3_early", o3_valid, 0);
        tick();
        check("t5_s3_valid", o3_valid, 1);
        check("t5_s3_alu", o3_alu, 32'h77);

`ifdef PIPE_PERF_CNT_EN
        // 6) stall counter saturation
        do_reset();
        out_ready = 1'b0;
        push(6);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("t6_stall_10", o1_stall_cnt, 10);
        repeat (10) tick();
        check("t6_stall_sat", o1_stall_cnt, 15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
